// File: rtl/gpu_pkg.sv
// Shared constants for the core pipeline: core-state encoding, fetcher and LSU codes.
// Imported by the scheduler and anything that decodes core_state.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

    function automatic logic lsu_is_busy(input logic [1:0] s);
        return (s == LSU_REQUESTING) || (s == LSU_WAITING);
    endfunction

endpackage

// File: rtl/divergence_stack.sv
// LIFO of {resume pc, lane mask} entries for lanes parked by a divergent branch.
// Push and pop are never requested together; contents are not reset, only the pointer.
module divergence_stack #(
    parameter int DEPTH   = 4,
    parameter int PC_BITS = 8,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [PC_BITS-1:0] push_pc,
    input  logic [LANES-1:0]   push_mask,
    output logic [PC_BITS-1:0] top_pc,
    output logic [LANES-1:0]   top_mask,
    output logic               empty,
    output logic               full
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]   sp;
    logic [PC_BITS-1:0] pc_mem   [DEPTH];
    logic [LANES-1:0]   mask_mem [DEPTH];
    logic [IDX_W-1:0]   top_idx;

    assign empty    = (sp == '0);
    assign full     = (sp == PTR_W'(DEPTH));
    // When empty the index wraps; top_* are then don't-care.
    assign top_idx  = IDX_W'(sp - 1'b1);
    assign top_pc   = pc_mem[top_idx];
    assign top_mask = mask_mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            pc_mem[IDX_W'(sp)]   <= push_pc;
            mask_mem[IDX_W'(sp)] <= push_mask;
            sp                   <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/divergent_scheduler.sv
// Per-block warp scheduler: walks the core pipeline states and splits/re-merges
// thread lanes on divergent next-PCs using a reconvergence stack.
module divergent_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int STACK_DEPTH       = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    input  logic                                   decoded_mem_read_enable,
    input  logic                                   decoded_mem_write_enable,
    input  logic                                   decoded_ret,
    input  logic [2:0]                             fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
    input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
    output logic [PC_BITS-1:0]                     current_pc,
    output logic [THREADS_PER_BLOCK-1:0]           active_mask,
    output logic [2:0]                             core_state,
    output logic                                   done,
    output logic                                   diverge_error
);

    localparam int T   = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    core_state_t        state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d, pc_lo, pc_b, top_pc;
    logic [T-1:0]       mask_q, mask_d, launch_mask, group_a, group_b, top_mask;
    logic               done_q, done_d, err_q, err_d;
    logic               push, pop, stk_empty, stk_full, lsu_busy, b_mismatch;
    logic               unused_mem_flags;

    // Every instruction walks REQUEST/WAIT; the access flags do not alter sequencing.
    assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

    divergence_stack #(
        .DEPTH  (STACK_DEPTH),
        .PC_BITS(PC_BITS),
        .LANES  (T)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_pc  (pc_b),
        .push_mask(group_b),
        .top_pc   (top_pc),
        .top_mask (top_mask),
        .empty    (stk_empty),
        .full     (stk_full)
    );

    // Lane analysis: launch mask, LSU busy, lowest next PC and the A/B split.
    always_comb begin
        launch_mask = '0;
        lsu_busy    = 1'b0;
        pc_lo       = '1;
        group_a     = '0;
        group_b     = '0;
        pc_b        = '0;
        b_mismatch  = 1'b0;
        for (int i = 0; i < T; i++) begin
            launch_mask[i] = thread_count > TCW'(i);
            if (mask_q[i] && lsu_is_busy(lsu_state[2*i +: 2])) lsu_busy = 1'b1;
            if (mask_q[i] && next_pc[i*PC_BITS +: PC_BITS] < pc_lo)
                pc_lo = next_pc[i*PC_BITS +: PC_BITS];
        end
        for (int i = 0; i < T; i++) begin
            if (mask_q[i]) begin
                if (next_pc[i*PC_BITS +: PC_BITS] == pc_lo) group_a[i] = 1'b1;
                else                                        group_b[i] = 1'b1;
            end
        end
        for (int i = T - 1; i >= 0; i--) begin
            if (group_b[i]) pc_b = next_pc[i*PC_BITS +: PC_BITS];
        end
        for (int i = 0; i < T; i++) begin
            if (group_b[i] && next_pc[i*PC_BITS +: PC_BITS] != pc_b) b_mismatch = 1'b1;
        end
    end

    // start is a level request honoured only in IDLE; done stays high until reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        done_d  = done_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    if (thread_count == '0) begin
                        done_d  = 1'b1;
                        state_d = CORE_DONE;
                    end else begin
                        mask_d  = launch_mask;
                        state_d = CORE_FETCH;
                    end
                end
            end
            CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT:    if (!lsu_busy) state_d = CORE_EXECUTE;
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (decoded_ret) begin
                    if (stk_empty) begin
                        done_d  = 1'b1;
                        state_d = CORE_DONE;
                    end else begin
                        pop     = 1'b1;
                        pc_d    = top_pc;
                        mask_d  = top_mask;
                        state_d = CORE_FETCH;
                    end
                end else if (group_b == '0) begin
                    pc_d    = pc_lo;
                    state_d = CORE_FETCH;
                    if (!stk_empty && top_pc == pc_lo) begin
                        pop    = 1'b1;
                        mask_d = mask_q | top_mask;
                    end
                end else begin
                    if (b_mismatch) err_d = 1'b1;
                    if (stk_full) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = CORE_DONE;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_lo;
                        mask_d  = group_a;
                        state_d = CORE_FETCH;
                    end
                end
            end
            CORE_DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CORE_IDLE;
            pc_q    <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign current_pc    = pc_q;
    assign active_mask   = mask_q;
    assign core_state    = state_q;
    assign done          = done_q;
    assign diverge_error = err_q;

endmodule
